// File: rtl/bit_serial_alu_seq.sv
// bit_serial_alu_seq: executes one WIDTH-bit ALU operation by driving an
// external one-bit ALU slice once per clock, LSB first, and assembling the
// word result, signed overflow, zero flag and set-less-than result.
// Optional feature macro: BSALU_ZERO_FLAG_EN (zero-flag tracker). When it is
// undefined, `zero` is tied low and no tracker state exists.
module bit_serial_alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [5:0]       ctl,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             zero,
  output logic             illegal,
  output logic [5:0]       slice_ctl,
  output logic             slice_a,
  output logic             slice_b,
  output logic             slice_invb,
  output logic             slice_cin,
  input  logic             slice_sum,
  input  logic             slice_carry
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  localparam logic [5:0] CTL_ADD = 6'd32;
  localparam logic [5:0] CTL_SUB = 6'd34;
  localparam logic [5:0] CTL_AND = 6'd36;
  localparam logic [5:0] CTL_OR  = 6'd37;
  localparam logic [5:0] CTL_SLT = 6'd42;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // One of the five supported function codes.
  function automatic logic is_legal(input logic [5:0] c);
    return (c == CTL_ADD) || (c == CTL_SUB) || (c == CTL_AND) ||
           (c == CTL_OR)  || (c == CTL_SLT);
  endfunction

  // Functions that subtract: the slice inverts b and the chain starts with carry 1.
  function automatic logic needs_invb(input logic [5:0] c);
    return (c == CTL_SUB) || (c == CTL_SLT);
  endfunction

  // Functions whose carry chain defines a signed overflow.
  function automatic logic is_arith(input logic [5:0] c);
    return (c == CTL_ADD) || (c == CTL_SUB) || (c == CTL_SLT);
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [5:0]         ctl_q, ctl_d;
  logic               invb_q, invb_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               overflow_q, overflow_d;
  logic               illegal_q, illegal_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic accept_s;
  logic start_legal_s;
  logic last_bit_s;
  logic cin_s;
  logic fix_bit_s;

  assign accept_s      = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign start_legal_s = is_legal(ctl);
  assign last_bit_s    = (cnt_q == LAST_BIT);
  // The first bit takes the subtract carry-in; later bits ripple the stored carry.
  assign cin_s         = (cnt_q == {CW{1'b0}}) ? invb_q : carry_q;
  // slt: sign of (a-b) corrected by overflow gives the signed less-than bit.
  assign fix_bit_s     = result_q[WIDTH-1] ^ overflow_q;

  assign slice_ctl  = ctl_q;
  assign slice_a    = a_q[0];
  assign slice_b    = b_q[0];
  assign slice_invb = invb_q;
  assign slice_cin  = cin_s;

  // Next-state and datapath update for the sequencer.
  always_comb begin
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    ctl_d      = ctl_q;
    invb_d     = invb_q;
    cnt_d      = cnt_q;
    carry_d    = carry_q;
    result_d   = result_q;
    overflow_d = overflow_q;
    illegal_d  = 1'b0;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept_s && start_legal_s) begin
          state_d    = S_RUN;
          a_d        = a;
          b_d        = b;
          ctl_d      = ctl;
          invb_d     = needs_invb(ctl);
          cnt_d      = {CW{1'b0}};
          carry_d    = 1'b0;
          result_d   = {WIDTH{1'b0}};
          overflow_d = 1'b0;
        end else if (accept_s) begin
          state_d    = S_DONE;
          result_d   = {WIDTH{1'b0}};
          overflow_d = 1'b0;
          illegal_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        result_d = {slice_sum, result_q[WIDTH-1:1]};
        carry_d  = slice_carry;
        a_d      = {1'b0, a_q[WIDTH-1:1]};
        b_d      = {1'b0, b_q[WIDTH-1:1]};
        cnt_d    = cnt_q + CW'(1);
        if (last_bit_s) begin
          overflow_d = is_arith(ctl_q) ? (cin_s ^ slice_carry) : 1'b0;
          state_d    = (ctl_q == CTL_SLT) ? S_FIX : S_DONE;
        end else begin
          state_d = S_RUN;
        end
      end
      S_FIX: begin
        result_d   = {{(WIDTH-1){1'b0}}, fix_bit_s};
        overflow_d = 1'b0;
        state_d    = S_DONE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy_d = (state_d == S_RUN) || (state_d == S_FIX);
  assign done_d = (state_d == S_DONE);

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      a_q        <= {WIDTH{1'b0}};
      b_q        <= {WIDTH{1'b0}};
      ctl_q      <= 6'd0;
      invb_q     <= 1'b0;
      cnt_q      <= {CW{1'b0}};
      carry_q    <= 1'b0;
      result_q   <= {WIDTH{1'b0}};
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      ctl_q      <= ctl_d;
      invb_q     <= invb_d;
      cnt_q      <= cnt_d;
      carry_q    <= carry_d;
      result_q   <= result_d;
      overflow_q <= overflow_d;
      illegal_q  <= illegal_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign result   = result_q;
  assign overflow = overflow_q;
  assign illegal  = illegal_q;

`ifdef BSALU_ZERO_FLAG_EN
  logic ztrk_q, ztrk_d;
  logic zero_q, zero_d;

  // Zero tracker: OR of sum bits during RUN, re-derived from the slt bit in FIX.
  always_comb begin
    ztrk_d = ztrk_q;
    zero_d = zero_q;
    if (accept_s) begin
      ztrk_d = 1'b0;
      // An illegal request completes at once with a zero result.
      zero_d = start_legal_s ? 1'b0 : 1'b1;
    end else if (state_q == S_RUN) begin
      ztrk_d = ztrk_q | slice_sum;
      if (last_bit_s && (ctl_q != CTL_SLT)) begin
        zero_d = ~(ztrk_q | slice_sum);
      end else begin
        zero_d = zero_q;
      end
    end else if (state_q == S_FIX) begin
      ztrk_d = fix_bit_s;
      zero_d = ~fix_bit_s;
    end else begin
      ztrk_d = ztrk_q;
      zero_d = zero_q;
    end
  end

  // Zero tracker and registered zero flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ztrk_q <= 1'b0;
      zero_q <= 1'b0;
    end else begin
      ztrk_q <= ztrk_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;
`else
  assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_bit_serial_alu_seq.sv
// Self-checking bench for bit_serial_alu_seq. A behavioural one-bit slice is
// attached to the slice ports; expected word results come from plain
// arithmetic on the operands, checked every cycle of each operation.
module tb_bit_serial_alu_seq;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [5:0]    ctl;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          busy;
  logic          done;
  logic [W-1:0]  result;
  logic          overflow;
  logic          zero;
  logic          illegal;
  logic [5:0]    slice_ctl;
  logic          slice_a;
  logic          slice_b;
  logic          slice_invb;
  logic          slice_cin;
  logic          slice_sum;
  logic          slice_carry;
  logic          bb_s;

  int checks;
  int errors;

  bit_serial_alu_seq #(.WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .ctl        (ctl),
    .a          (a),
    .b          (b),
    .busy       (busy),
    .done       (done),
    .result     (result),
    .overflow   (overflow),
    .zero       (zero),
    .illegal    (illegal),
    .slice_ctl  (slice_ctl),
    .slice_a    (slice_a),
    .slice_b    (slice_b),
    .slice_invb (slice_invb),
    .slice_cin  (slice_cin),
    .slice_sum  (slice_sum),
    .slice_carry(slice_carry)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural one-bit ALU slice.
  always_comb begin
    slice_sum   = 1'b0;
    slice_carry = 1'b0;
    bb_s        = slice_b ^ slice_invb;
    case (slice_ctl)
      6'd32, 6'd34, 6'd42: begin
        slice_sum   = slice_a ^ bb_s ^ slice_cin;
        slice_carry = (slice_a & bb_s) | (slice_a & slice_cin) | (bb_s & slice_cin);
      end
      6'd36: slice_sum = slice_a & slice_b;
      6'd37: slice_sum = slice_a | slice_b;
      default: begin
        slice_sum   = 1'b0;
        slice_carry = 1'b0;
      end
    endcase
  end

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: word result, overflow, illegal and cycles from accept to done.
  function automatic void model(input logic [31:0] x, input logic [31:0] y,
                                input logic [5:0] c, output logic [31:0] r,
                                output logic ov, output logic ill, output int lat);
    r = 32'd0; ov = 1'b0; ill = 1'b0; lat = W;
    case (c)
      6'd32: begin r = x + y; ov = (x[31] == y[31]) && (r[31] != x[31]); end
      6'd34: begin r = x - y; ov = (x[31] != y[31]) && (r[31] != x[31]); end
      6'd36: r = x & y;
      6'd37: r = x | y;
      6'd42: begin r = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0; lat = W + 1; end
      default: begin ill = 1'b1; lat = 0; end
    endcase
  endfunction

  // Carry into bit k of x + (y ^ inv) + inv.
  function automatic logic exp_cin(input logic [31:0] x, input logic [31:0] y,
                                   input logic inv, input int k);
    logic [63:0] m, s, yy;
    m  = (64'd1 << k) - 64'd1;
    yy = {32'd0, (inv ? ~y : y)};
    s  = ({32'd0, x} & m) + (yy & m) + {63'd0, inv};
    return s[k];
  endfunction

  // Issue one operation at a negedge and check every cycle until done.
  task automatic do_op(input logic [31:0] ta, input logic [31:0] tbv, input logic [5:0] tc,
                       input bit mid_pulse, input bit b2b);
    logic [31:0] er;
    logic eov, eill, inv, ez;
    int lat;
    model(ta, tbv, tc, er, eov, eill, lat);
    inv = (tc == 6'd34) || (tc == 6'd42);
`ifdef BSALU_ZERO_FLAG_EN
    ez = (er == 32'd0);
`else
    ez = 1'b0;
`endif
    a = ta; b = tbv; ctl = tc; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k <= lat; k++) begin
      @(negedge clk);
      chk1("busy", busy, (k < lat));
      chk1("done", done, (k == lat));
      if (!eill && k < W) begin
        chk32("slice_ctl", {26'd0, slice_ctl}, {26'd0, tc});
        chk1("slice_invb", slice_invb, inv);
        chk1("slice_a", slice_a, ta[k]);
        chk1("slice_b", slice_b, tbv[k]);
        if (tc != 6'd36 && tc != 6'd37) chk1("slice_cin", slice_cin, exp_cin(ta, tbv, inv, k));
      end
      if (!eill && k == 0) chk32("result_clear", result, 32'd0);
      if (k == lat) begin
        chk32("result", result, er);
        chk1("overflow", overflow, eov);
        chk1("illegal", illegal, eill);
        chk1("zero", zero, ez);
      end
      if (mid_pulse && k == 10) begin
        start = 1'b1; a = ~ta; b = ~tbv; ctl = 6'd37;
      end
      if (mid_pulse && k == 11) start = 1'b0;
    end
    if (!b2b) begin
      @(negedge clk);
      chk1("done_pulse_end", done, 1'b0);
      chk1("busy_idle", busy, 1'b0);
      chk1("illegal_end", illegal, 1'b0);
      chk32("result_held", result, er);
    end
  endtask

  // Model pin: hand-computed expectations from the test plan.
  task automatic pin(input logic [31:0] x, input logic [31:0] y, input logic [5:0] c,
                     input logic [31:0] er, input logic eov);
    logic [31:0] r; logic ov, ill; int lat;
    model(x, y, c, r, ov, ill, lat);
    chk32("model_result", r, er);
    chk1("model_ovf", ov, eov);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] codes [0:8];
    logic [31:0] x, y;
    logic [5:0] c;
    bit bb;
    codes[0] = 6'd32; codes[1] = 6'd34; codes[2] = 6'd36; codes[3] = 6'd37;
    codes[4] = 6'd42; codes[5] = 6'd0;  codes[6] = 6'd33; codes[7] = 6'd63;
    codes[8] = 6'd42;
    checks = 0; errors = 0;
    rst_n = 1'b0; start = 1'b0; ctl = 6'd0; a = 32'd0; b = 32'd0;
    #12;
    chk1("rst_busy", busy, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_result", result, 32'd0);
    chk1("rst_overflow", overflow, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_illegal", illegal, 1'b0);
    chk32("rst_slice_ctl", {26'd0, slice_ctl}, 32'd0);
    chk32("rst_slice_bits", {28'd0, slice_a, slice_b, slice_invb, slice_cin}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    pin(32'd5, 32'd3, 6'd32, 32'd8, 1'b0);
    pin(32'd3, 32'd5, 6'd34, 32'hFFFFFFFE, 1'b0);
    pin(32'h7FFFFFFF, 32'd1, 6'd32, 32'h80000000, 1'b1);
    pin(32'hFFFFFFFF, 32'd1, 6'd42, 32'd1, 1'b0);
    pin(32'h80000000, 32'd1, 6'd42, 32'd1, 1'b0);
    pin(32'd1, 32'hFFFFFFFF, 6'd42, 32'd0, 1'b0);
    pin(32'hF0F0F0F0, 32'hFF00FF00, 6'd36, 32'hF000F000, 1'b0);
    pin(32'hF0F0F0F0, 32'hFF00FF00, 6'd37, 32'hFFF0FFF0, 1'b0);

    do_op(32'd5, 32'd3, 6'd32, 1'b0, 1'b0);
    do_op(32'd3, 32'd5, 6'd34, 1'b0, 1'b0);
    do_op(32'h7FFFFFFF, 32'd1, 6'd32, 1'b0, 1'b0);
    do_op(32'hFFFFFFFF, 32'd1, 6'd42, 1'b0, 1'b0);
    do_op(32'h80000000, 32'd1, 6'd42, 1'b0, 1'b0);
    do_op(32'd1, 32'hFFFFFFFF, 6'd42, 1'b0, 1'b0);
    do_op(32'hF0F0F0F0, 32'hFF00FF00, 6'd36, 1'b0, 1'b0);
    do_op(32'hF0F0F0F0, 32'hFF00FF00, 6'd37, 1'b0, 1'b0);
    do_op(32'h12345678, 32'h9ABCDEF0, 6'd0, 1'b0, 1'b0);
    do_op(32'h0000ABCD, 32'h00001234, 6'd34, 1'b1, 1'b0);
    do_op(32'd10, 32'd20, 6'd32, 1'b0, 1'b1);
    do_op(32'd7, 32'd9, 6'd42, 1'b0, 1'b1);
    do_op(32'd1, 32'd2, 6'd33, 1'b0, 1'b1);
    do_op(32'd7, 32'd7, 6'd34, 1'b0, 1'b0);
    do_op(32'd7, 32'd6, 6'd34, 1'b0, 1'b0);

    // Reset asserted at bit 10 of an add aborts without a done pulse.
    a = 32'd5; b = 32'd3; ctl = 6'd32; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk1("abort_busy", busy, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk32("abort_result", result, 32'd0);
    chk1("abort_overflow", overflow, 1'b0);
    chk1("abort_zero", zero, 1'b0);
    chk1("abort_illegal", illegal, 1'b0);
    chk32("abort_slice_ctl", {26'd0, slice_ctl}, 32'd0);
    chk32("abort_slice_bits", {28'd0, slice_a, slice_b, slice_invb, slice_cin}, 32'd0);
    repeat (3) begin
      @(negedge clk);
      chk1("abort_no_done", done, 1'b0);
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk1("post_abort_done", done, 1'b0);
      chk1("post_abort_busy", busy, 1'b0);
    end

    for (int i = 0; i < 40; i++) begin
      x  = $urandom;
      y  = ($urandom_range(0, 5) == 0) ? x : $urandom;
      c  = codes[$urandom_range(0, 8)];
      bb = ($urandom_range(0, 3) == 0) && (i != 39);
      do_op(x, y, c, ($urandom_range(0, 4) == 0), bb);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
